program_fetch_unit: RTL
=======================

Name: program_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the program ROM; drives the ROM address and captures its 4-bit opcode.
- Presents each opcode to the decode/execute stage over a valid/ready handshake.
- Owns the program counter. Supports free-run, single-step, skip-next (conditional skip from execute) and halt at a programmable end address.

Parameters:
ADDR_WIDTH, 8, width of program counter and ROM address.
END_ADDR, 255, last program address; accepting the instruction at this address halts fetch.
NOP_OPCODE, 4'b0111, value driven on instrOut when no instruction is held (CLR).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
runIn  input  1  level; 1 = continuous fetch, 0 = single-step mode.
stepIn  input  1  single-cycle pulse; fetch exactly one instruction when idle.
addressOut  output  ADDR_WIDTH  ROM address (equals PC).
instrIn  input  4  opcode from ROM, combinational in addressOut.
instrOut  output  4  registered opcode to decode.
instrValid  output  1  instrOut holds an unaccepted instruction.
instrReady  input  1  decode accepts instrOut when instrValid && instrReady.
skipIn  input  1  sampled only on the accept cycle; 1 = discard the next sequential instruction.
haltedOut  output  1  fetch has stopped at END_ADDR.
loopCountOut  output  8  program wrap count (see Optional Feature).

Interface decision: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Reset values: pc = 0, addressOut = 0, instrOut = NOP_OPCODE, instrValid = 0, haltedOut = 0, loopCountOut = 0, state = IDLE.
- addressOut = pc at all times. instrIn is valid in the same cycle.
- State IDLE:
  - If runIn or stepIn, go to FETCH next edge.
  - Otherwise stay.
- State FETCH (one cycle):
  - Capture instrOut <= instrIn and set instrValid <= 1.
  - Go to HOLD.
- State HOLD:
  - instrOut and instrValid are stable until accept.
  - On accept: instrValid <= 0 and instrOut <= NOP_OPCODE.
  - Next pc = pc + 1 + skipIn, modulo 2^ADDR_WIDTH.
  - Go to HALT if pc == END_ADDR, or if skipIn && pc + 1 == END_ADDR.
  - Otherwise go to FETCH if runIn, else IDLE.
- State HALT:
  - haltedOut = 1, pc frozen, instrValid = 0.
  - Only reset exits HALT.
- Throughput: with runIn = 1 and instrReady tied high, one instruction every 2 cycles. First instrValid is 2 edges after runIn is sampled in IDLE.
- stepIn asserted in FETCH, HOLD or HALT is ignored, not queued.
- runIn dropped in FETCH or HOLD: the current instruction completes its handshake, then the block returns to IDLE.
- skipIn with no accept in the same cycle: ignored.
- Wrap: pc = 2^ADDR_WIDTH - 1 with END_ADDR larger is not possible. pc + 1 + skipIn wraps modulo 2^ADDR_WIDTH if END_ADDR = 2^ADDR_WIDTH - 1 and skip targets beyond it, but the halt rule fires first.
- Reset asserted in any state, including mid-handshake, restores reset values on that edge. A held instruction is dropped.
- END_ADDR must be < 2^ADDR_WIDTH; an elaboration-time check is required.

Optional Feature:
- Macro: FETCH_LOOP_EN.
- Defined:
  - Reaching the halt condition reloads pc = 0 instead of entering HALT.
  - Increments loopCountOut (saturating at 255).
  - Continues per runIn; haltedOut stays 0.
- Undefined:
  - HALT behaviour as above.
  - loopCountOut is tied to 0.

Test Plan:
- Reset, runIn = 1, instrReady = 1, ROM returns the address low nibble: instrOut sequence 0,1,2,...,7 with END_ADDR = 7. haltedOut = 1 after the accept at pc = 7; addressOut stays 7.
- runIn = 0, stepIn pulse x3: exactly three instructions (addresses 0,1,2). Then IDLE, instrValid = 0, addressOut = 3. Extra stepIn pulses during HOLD produce no extra fetch.
- instrReady low for 5 cycles in HOLD at pc = 2: instrOut and instrValid stable for 5 cycles, pc stays 2. On accept, next addressOut = 3.
- skipIn = 1 on accept at pc = 4: next addressOut = 6; the opcode at address 5 is never presented. With END_ADDR = 7, skipIn at pc = 6: HALT, address 7 not presented.
- Reset asserted during HOLD at pc = 5: next cycle pc = 0, instrValid = 0, instrOut = 4'b0111, state IDLE.
- With FETCH_LOOP_EN and END_ADDR = 3, free run: addresses 0,1,2,3,0,1,... and loopCountOut increments on each wrap. haltedOut never asserts.

Source files
------------

// File: rtl/program_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM address/opcode plus the decode valid/ready handshake.
// master = fetch unit side, slave = ROM/decode side.
interface program_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addressOut;
    logic [3:0]            instrIn;
    logic [3:0]            instrOut;
    logic                  instrValid;
    logic                  instrReady;
    logic                  skipIn;

    modport master (
        output addressOut, instrOut, instrValid,
        input  instrIn, instrReady, skipIn
    );

    modport slave (
        input  addressOut, instrOut, instrValid,
        output instrIn, instrReady, skipIn
    );
endinterface

// File: rtl/program_fetch_unit.sv
// Instruction fetch: owns the PC, captures ROM opcodes, hands them to decode.
// Optional FETCH_LOOP_EN: wrap the PC to 0 at END_ADDR and count wraps instead of halting.
module program_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned END_ADDR   = 255,
    parameter logic [3:0]  NOP_OPCODE = 4'b0111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                runIn,
    input  logic                stepIn,
    program_fetch_unit_if.master bus,
    output logic                haltedOut,
    output logic [7:0]          loopCountOut
);

    if (64'(END_ADDR) >= (64'd1 << ADDR_WIDTH)) begin : g_bad_end_addr
        $error("program_fetch_unit: END_ADDR does not fit in ADDR_WIDTH bits");
    end

    localparam logic [ADDR_WIDTH-1:0] END_PC = ADDR_WIDTH'(END_ADDR);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] pc, pc_d, pc_inc;
    logic [3:0]            instr, instr_d;
    logic                  valid, valid_d;
    logic                  accept, at_end;

    assign pc_inc = pc + ADDR_WIDTH'(1);
    assign accept = valid && bus.instrReady;
    // A skip from END_ADDR-1 would step over the end address, so it halts too.
    assign at_end = (pc == END_PC) || (bus.skipIn && (pc_inc == END_PC));

`ifdef FETCH_LOOP_EN
    logic [7:0] loop_cnt, loop_d;
`endif

    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr;
        valid_d = valid;
`ifdef FETCH_LOOP_EN
        loop_d  = loop_cnt;
`endif
        case (state)
            IDLE: if (runIn || stepIn) state_d = FETCH;
            FETCH: begin
                instr_d = bus.instrIn;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (accept) begin
                valid_d = 1'b0;
                instr_d = NOP_OPCODE;
                if (at_end) begin
`ifdef FETCH_LOOP_EN
                    pc_d    = '0;
                    if (loop_cnt != 8'hFF) loop_d = loop_cnt + 8'd1;
                    state_d = runIn ? FETCH : IDLE;
`else
                    state_d = HALT;
`endif
                end else begin
                    pc_d    = pc_inc + ADDR_WIDTH'(bus.skipIn);
                    state_d = runIn ? FETCH : IDLE;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            instr <= NOP_OPCODE;
            valid <= 1'b0;
`ifdef FETCH_LOOP_EN
            loop_cnt <= '0;
`endif
        end else begin
            state <= state_d;
            pc    <= pc_d;
            instr <= instr_d;
            valid <= valid_d;
`ifdef FETCH_LOOP_EN
            loop_cnt <= loop_d;
`endif
        end
    end

    assign bus.addressOut = pc;
    assign bus.instrOut   = instr;
    assign bus.instrValid = valid;
    assign haltedOut      = (state == HALT);
`ifdef FETCH_LOOP_EN
    assign loopCountOut   = loop_cnt;
`else
    assign loopCountOut   = 8'd0;
`endif

endmodule
